uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DBit, default 8: number of data bits per frame (5..8).
REQ-002 Parameter SBit, default 16: stop-bit length in s_tick periods (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_tick  input  1  16x-baud enable pulse, one clk wide; all bit timing counts s_tick, not clk.
REQ-006 rx  input  1  asynchronous serial line; idle high; LSB first.
REQ-007 rx_dataOut  output  8  last received byte; unused high bits are 0 when DBit<8.
REQ-008 rx_done_tick  output  1  one-clk pulse marking a completed frame.
REQ-009 frame_err  output  1  stop bit sampled low in the last frame; valid with rx_done_tick, held until the next one.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized rx_s.
REQ-011 States: IDLE, START, DATA, STOP (plus PARITY, see REQ-030); tick counter 4 bits, bit counter 3 bits.
REQ-012 IDLE: when armed and rx_s==0 -> START, tick counter cleared.
REQ-013 START: on s_tick, tick counter increments; at count 7 (mid-bit), rx_s==0 -> DATA with both counters cleared; rx_s==1 -> IDLE (false start, no outputs change).
REQ-014 DATA: on s_tick at count 15, rx_s SHALL shift into the MSB of the shift register, tick counter clears and bit counter increments; after bit DBit-1 -> STOP.
REQ-015 Shift register SHALL be right-justified on output: rx_dataOut = shreg >> (8-DBit).
REQ-016 STOP: on s_tick at count SBit-1 (counter widened to fit SBit), rx_s is sampled; rx_dataOut and frame_err (= ~rx_s) are loaded; rx_done_tick is high for exactly the next clk cycle; -> IDLE.
REQ-017 No s_tick SHALL mean no state or counter change; the FSM holds indefinitely.
REQ-018 Latency: rx_done_tick rises one clk after the edge taking the final stop sample; rx_dataOut is valid in the same cycle and stable until the next rx_done_tick.
REQ-019 Break handling: after a frame with frame_err=1, IDLE SHALL stay disarmed until rx_s==1 is seen, so a held-low line never retriggers.
REQ-020 A start edge arriving during STOP SHALL be ignored; a new frame begins only from IDLE.

Reset
REQ-021 reset SHALL force IDLE, armed=1, counters 0, shift register 0, rx_dataOut=0, rx_done_tick=0, frame_err=0, synchronizer flops=1.
REQ-022 reset mid-frame SHALL discard the partial frame with no rx_done_tick.
REQ-023 reset SHALL override s_tick when both are high in the same cycle.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: state PARITY is inserted between DATA and STOP; it samples one even-parity bit at count 15 and output parity_err (1 bit, reset 0) is updated with rx_done_tick (1 = XOR of data and parity bit is 1).
REQ-031 Macro undefined: no PARITY state and no parity_err port; frame is start + DBit + stop.

Structure
REQ-040 Shared package uart_pkg SHALL hold the state enum (IDLE, START, DATA, STOP, PARITY), OVERSAMPLE=16 and MID_SAMPLE=7, for reuse by the transmitter and the baud generator.
REQ-041 One sub-module, uart_rx_sync (2-flop synchronizer, reset value 1), instantiated for rx.

Verification (s_tick every 4 clk, 8N1 unless stated)
REQ-050 Frame 0x55 -> rx_dataOut=0x55, rx_done_tick high exactly 1 clk, frame_err=0.
REQ-051 rx low for 3 s_tick then high -> return to IDLE, no rx_done_tick, rx_dataOut unchanged.
REQ-052 Data 0xA3 with stop bit low, rx held low 40 ticks -> rx_dataOut=0xA3, frame_err=1, single pulse, no second frame until rx high.
REQ-053 reset during data bit 4 of 0x3C, then frame 0x0F -> no pulse for 0x3C, rx_dataOut=0x0F.
REQ-054 Back-to-back 0x00 then 0xFF, no idle gap -> two pulses, values 0x00 then 0xFF, frame_err=0.
REQ-055 UART_RX_PARITY_EN, data 0x07 with parity bit 0 -> parity_err=1; parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// reused by the receiver, transmitter and baud generator.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta->q a real two-stage pipeline;
    // blocking ones would collapse it into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver (start + DBit data + optional even parity + stop).
// Define UART_RX_PARITY_EN to add the parity bit and the parity_err output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBit = 8,
    parameter int SBit = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       rx,
    output logic [7:0] rx_dataOut,
    output logic       rx_done_tick,
    output logic       frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    // Tick counter is 4 bits, widened only when a long stop bit needs it.
    localparam int TW = ($clog2(SBit) > 4) ? $clog2(SBit) : 4;
    localparam logic [TW-1:0] MID_LAST  = TW'(MID_SAMPLE);
    localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP_LAST = TW'(SBit - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [2:0]    DATA_LAST = 3'(DBit - 1);

`ifdef UART_RX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    uart_state_e   state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          armed;
    logic          rx_s;
`ifdef UART_RX_PARITY_EN
    logic          par_bit;
`endif

    uart_rx_sync u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            armed        <= 1'b1;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_dataOut   <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // After a framing error the line must go high before re-arming.
                    if (!armed) begin
                        if (rx_s) armed <= 1'b1;
                    end else if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: if (s_tick) begin
                    if (tick_cnt == MID_LAST) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
                DATA: if (s_tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt <= '0;
                        shreg    <= {rx_s, shreg[7:1]};
                        if (bit_cnt == DATA_LAST) state <= AFTER_DATA;
                        else bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (s_tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt <= '0;
                        par_bit  <= rx_s;
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
`endif
                STOP: if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        tick_cnt     <= '0;
                        rx_dataOut   <= shreg >> (8 - DBit);
                        frame_err    <= ~rx_s;
                        armed        <= rx_s;
                        rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err   <= (^(shreg >> (8 - DBit))) ^ par_bit;
`endif
                        state        <= IDLE;
                    end else begin
                        tick_cnt <= tick_cnt + TICK_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver (8N1, s_tick every 4 clk);
// frames are checked against an expected-frame queue as rx_done_tick fires.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int CLK_PER_TICK = 4;
    localparam int BIT_CLKS     = 16 * CLK_PER_TICK;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       s_tick = 1'b0;
    logic       rx     = 1'b1;
    logic [7:0] rx_dataOut;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } frame_t;

    frame_t exp_q[$];
    frame_t got_f;
    int     checks    = 0;
    int     errors    = 0;
    int     exp_total = 0;
    int     pulses    = 0;
    logic   prev_done = 1'b0;

    uart_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx           (rx),
        .rx_dataOut   (rx_dataOut),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (CLK_PER_TICK - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bits(input logic b, input int nclk);
        rx = b;
        repeat (nclk) @(negedge clk);
    endtask

    // Reference: a frame yields its data byte, frame error when the stop bit
    // is low, and a parity error when data plus parity holds an odd count of ones.
    task automatic send_frame(input logic [7:0] data, input logic stop, input logic par);
        frame_t f;
        f.data = data;
        f.ferr = !stop;
        f.perr = (($countones(data) + int'(par)) % 2) == 1;
        exp_q.push_back(f);
        exp_total++;
        drive_bits(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bits(data[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        drive_bits(par, BIT_CLKS);
`endif
        drive_bits(stop, BIT_CLKS);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_done) check("done_width", rx_done_tick, 0);
            if (rx_done_tick) begin
                pulses++;
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    got_f = exp_q.pop_front();
                    check("frame_data", rx_dataOut, got_f.data);
                    check("frame_err", frame_err, got_f.ferr);
`ifdef UART_RX_PARITY_EN
                    check("parity_err", parity_err, got_f.perr);
`endif
                end
            end
        end
        prev_done = rx_done_tick;
    end

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       par;
        int         gap;

        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_data", rx_dataOut, 0);
        check("rst_done", rx_done_tick, 0);
        check("rst_ferr", frame_err, 0);

        send_frame(8'h55, 1'b1, 1'b0);
        drive_bits(1'b1, 2 * BIT_CLKS);
        check("f55_pulses", pulses, exp_total);
        check("f55_data", rx_dataOut, 8'h55);
        check("f55_ferr", frame_err, 0);

        drive_bits(1'b0, 3 * CLK_PER_TICK);
        drive_bits(1'b1, 2 * BIT_CLKS);
        check("false_start_pulses", pulses, exp_total);
        check("false_start_data", rx_dataOut, 8'h55);

        send_frame(8'hA3, 1'b0, 1'b0);
        drive_bits(1'b0, 40 * CLK_PER_TICK);
        check("break_pulses", pulses, exp_total);
        check("break_data", rx_dataOut, 8'hA3);
        check("break_ferr_held", frame_err, 1);
        drive_bits(1'b1, BIT_CLKS);
        send_frame(8'h5A, 1'b1, 1'b0);
        drive_bits(1'b1, BIT_CLKS);
        check("after_break_pulses", pulses, exp_total);
        check("after_break_ferr", frame_err, 0);

        d = 8'h3C;
        drive_bits(1'b0, BIT_CLKS);
        for (int i = 0; i < 4; i++) drive_bits(d[i], BIT_CLKS);
        drive_bits(d[4], BIT_CLKS / 2);
        reset = 1'b1;
        drive_bits(1'b1, 8);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_data", rx_dataOut, 0);
        check("midreset_ferr", frame_err, 0);
        drive_bits(1'b1, 2 * BIT_CLKS);
        check("midreset_pulses", pulses, exp_total);
        send_frame(8'h0F, 1'b1, 1'b0);
        drive_bits(1'b1, BIT_CLKS);
        check("f0f_data", rx_dataOut, 8'h0F);
        check("f0f_pulses", pulses, exp_total);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_bits(1'b1, BIT_CLKS);
        check("b2b_pulses", pulses, exp_total);
        check("b2b_data", rx_dataOut, 8'hFF);
        check("b2b_ferr", frame_err, 0);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bits(1'b1, BIT_CLKS);
        check("par0_err", parity_err, 1);
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bits(1'b1, BIT_CLKS);
        check("par1_err", parity_err, 0);
`endif

        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            par  = 1'($urandom);
            send_frame(d, stop, par);
            gap = stop ? $urandom_range(0, 8) : $urandom_range(2, 8);
            drive_bits(1'b1, gap * CLK_PER_TICK);
        end
        drive_bits(1'b1, 2 * BIT_CLKS);
        check("rand_pulses", pulses, exp_total);
        check("rand_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
